// File: rtl/glorb_pkg.sv
// Shared definitions for the glorb fetch path: word widths, fetch state
// encoding and the {pc, data} record carried through the fetch queue.
package glorb_pkg;

    localparam int IW        = 8;
    localparam int IMW       = 4;
    localparam int DEF_DEPTH = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [IMW-1:0] pc;
        logic [IW-1:0]  data;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: control from execute, instruction memory port and the
// decode-side valid/ready handshake. master = fetch stage, slave = its peers.
interface instr_fetch_if;
    import glorb_pkg::*;

    logic           start;
    logic           branch_taken;
    logic [IMW-1:0] branch_target;
    logic           imem_en;
    logic [IMW-1:0] imem_addr;
    logic [IW-1:0]  imem_rdata;
    logic           inst_valid;
    logic           inst_ready;
    logic [IW-1:0]  inst_data;
    logic [IMW-1:0] inst_pc;

    modport master (
        input  start, branch_taken, branch_target, imem_rdata, inst_ready,
        output imem_en, imem_addr, inst_valid, inst_data, inst_pc
    );

    modport slave (
        output start, branch_taken, branch_target, imem_rdata, inst_ready,
        input  imem_en, imem_addr, inst_valid, inst_data, inst_pc
    );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, data} entries. Flush beats a
// same-cycle push; DEPTH must be a power of two so pointers wrap for free.
module fetch_queue
    import glorb_pkg::*;
#(
    parameter  int DEPTH = DEF_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  fetch_entry_t  push_entry,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output fetch_entry_t  head
);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the fetch pc, issues reads to a one-cycle
// instruction memory, queues returned words and hands them to decode.
module instr_fetch
    import glorb_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = CW + 1;

    fetch_state_e   state_q, state_d;
    logic [IMW-1:0] fetch_pc_q, fetch_pc_d;
    logic [IMW-1:0] inflight_pc_q, inflight_pc_d;
    logic           inflight_q, inflight_d;
    logic           kill_q, kill_d;

    logic           redirect;
    logic [IMW-1:0] redirect_target;
    logic           inst_valid;
    logic           pop;
    logic           push;
    logic           issue;
    logic [OW-1:0]  occupancy;
    logic [CW-1:0]  q_count;
    fetch_entry_t   q_head;
    fetch_entry_t   push_entry;

    // start while running is treated as a redirect to 0 and wins over a branch
    always_comb begin
        redirect        = (state_q == RUN) && (bus.start || bus.branch_taken);
        redirect_target = bus.start ? '0 : bus.branch_target;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Occupancy counts the word still in flight so the queue can never overflow
    always_comb begin
        inst_valid = (q_count != '0) && !redirect;
        pop        = inst_valid && bus.inst_ready;
        occupancy  = OW'(q_count) + OW'(inflight_q) - OW'(pop);
        issue      = (state_q == RUN) && !redirect && (occupancy < OW'(DEPTH));

        bus.imem_en    = issue;
        bus.imem_addr  = fetch_pc_q;
        bus.inst_valid = inst_valid;
        bus.inst_data  = q_head.data;
        bus.inst_pc    = q_head.pc;
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = issue;
        kill_d        = redirect ? inflight_q : 1'b0;
        if (state_q == IDLE && bus.start) begin
            fetch_pc_d = '0;
        end else if (redirect) begin
            fetch_pc_d = redirect_target;
        end else if (issue) begin
            fetch_pc_d    = fetch_pc_q + IMW'(1);
            inflight_pc_d = fetch_pc_q;
        end
        push            = inflight_q && !kill_q;
        push_entry.pc   = inflight_pc_q;
        push_entry.data = bus.imem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= '0;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
            kill_q        <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            kill_q        <= kill_d;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect),
        .count      (q_count),
        .head       (q_head)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch; the memory model returns addr + 8'h10 one
// cycle after each read strobe.
module tb_instr_fetch;
    import glorb_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    instr_fetch_if bus_if ();

    instr_fetch #(
        .DEPTH (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.master)
    );

    always @(posedge clk) begin
        if (bus_if.imem_en) bus_if.imem_rdata <= IW'(bus_if.imem_addr) + 8'h10;
    end

    // Drive one cycle's inputs at the falling edge, then let outputs settle
    task automatic drive(input logic s, input logic b, input logic [IMW-1:0] t, input logic r);
        @(negedge clk);
        bus_if.start         = s;
        bus_if.branch_taken  = b;
        bus_if.branch_target = t;
        bus_if.inst_ready    = r;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n                = 1'b0;
        bus_if.start         = 1'b0;
        bus_if.branch_taken  = 1'b0;
        bus_if.branch_target = '0;
        bus_if.inst_ready    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n                = 1'b0;
        bus_if.start         = 1'b0;
        bus_if.branch_taken  = 1'b0;
        bus_if.branch_target = '0;
        bus_if.inst_ready    = 1'b0;
        bus_if.imem_rdata    = '0;
        #2;
        total++; if (bus_if.imem_en !== 1'b0) begin bad++; $display("FAIL reset_imem_en got=%b want=0", bus_if.imem_en); end
        total++; if (bus_if.imem_addr !== 4'h0) begin bad++; $display("FAIL reset_imem_addr got=%h want=0", bus_if.imem_addr); end
        total++; if (bus_if.inst_valid !== 1'b0) begin bad++; $display("FAIL reset_inst_valid got=%b want=0", bus_if.inst_valid); end
        total++; if (bus_if.inst_data !== 8'h00) begin bad++; $display("FAIL reset_inst_data got=%h want=00", bus_if.inst_data); end
        total++; if (bus_if.inst_pc !== 4'h0) begin bad++; $display("FAIL reset_inst_pc got=%h want=0", bus_if.inst_pc); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        logic [IMW-1:0] e;
        do_reset();
        drive(1'b1, 1'b0, '0, 1'b1);
        total++; if (bus_if.imem_en !== 1'b0) begin bad++; $display("FAIL stream_idle_en got=%b want=0", bus_if.imem_en); end
        drive(1'b0, 1'b0, '0, 1'b1);
        total++; if ({bus_if.imem_en, bus_if.imem_addr} !== 5'h10) begin bad++; $display("FAIL stream_c1_req got=%b/%h want=1/0", bus_if.imem_en, bus_if.imem_addr); end
        total++; if (bus_if.inst_valid !== 1'b0) begin bad++; $display("FAIL stream_c1_valid got=%b want=0", bus_if.inst_valid); end
        drive(1'b0, 1'b0, '0, 1'b1);
        total++; if ({bus_if.imem_en, bus_if.imem_addr} !== 5'h11) begin bad++; $display("FAIL stream_c2_req got=%b/%h want=1/1", bus_if.imem_en, bus_if.imem_addr); end
        total++; if (bus_if.inst_valid !== 1'b0) begin bad++; $display("FAIL stream_c2_valid got=%b want=0", bus_if.inst_valid); end
        for (int i = 0; i < 18; i++) begin
            drive(1'b0, 1'b0, '0, 1'b1);
            e = IMW'(i);
            total++;
            if (bus_if.inst_valid !== 1'b1 || bus_if.inst_pc !== e || bus_if.inst_data !== (8'h10 + IW'(e))) begin
                bad++;
                $display("FAIL stream_word%0d got=%b/%h/%h want=1/%h/%h", i, bus_if.inst_valid, bus_if.inst_pc, bus_if.inst_data, e, 8'h10 + IW'(e));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(1'b1, 1'b0, '0, 1'b0);
        drive(1'b0, 1'b0, '0, 1'b0);
        total++; if ({bus_if.imem_en, bus_if.imem_addr} !== 5'h10) begin bad++; $display("FAIL bp_c1_req got=%b/%h want=1/0", bus_if.imem_en, bus_if.imem_addr); end
        drive(1'b0, 1'b0, '0, 1'b0);
        total++; if ({bus_if.imem_en, bus_if.imem_addr} !== 5'h11) begin bad++; $display("FAIL bp_c2_req got=%b/%h want=1/1", bus_if.imem_en, bus_if.imem_addr); end
        for (int c = 3; c < 8; c++) begin
            drive(1'b0, 1'b0, '0, 1'b0);
            total++;
            if (bus_if.imem_en !== 1'b0 || bus_if.inst_valid !== 1'b1 || bus_if.inst_pc !== 4'h0) begin
                bad++;
                $display("FAIL bp_hold_c%0d got=en%b/v%b/pc%h want=en0/v1/pc0", c, bus_if.imem_en, bus_if.inst_valid, bus_if.inst_pc);
            end
        end
        drive(1'b0, 1'b0, '0, 1'b1);
        total++; if ({bus_if.imem_en, bus_if.imem_addr} !== 5'h12) begin bad++; $display("FAIL bp_resume_req got=%b/%h want=1/2", bus_if.imem_en, bus_if.imem_addr); end
        total++; if ({bus_if.inst_valid, bus_if.inst_pc} !== 5'h10) begin bad++; $display("FAIL bp_pop0 got=%b/%h want=1/0", bus_if.inst_valid, bus_if.inst_pc); end
        drive(1'b0, 1'b0, '0, 1'b1);
        total++; if ({bus_if.inst_valid, bus_if.inst_pc} !== 5'h11) begin bad++; $display("FAIL bp_pop1 got=%b/%h want=1/1", bus_if.inst_valid, bus_if.inst_pc); end
        drive(1'b0, 1'b0, '0, 1'b1);
        total++; if ({bus_if.inst_valid, bus_if.inst_pc, bus_if.inst_data} !== 13'h1212) begin bad++; $display("FAIL bp_pop2 got=%b/%h/%h want=1/2/12", bus_if.inst_valid, bus_if.inst_pc, bus_if.inst_data); end
    endtask

    task automatic test_redirect();
        do_reset();
        drive(1'b1, 1'b0, '0, 1'b1);
        for (int c = 1; c < 6; c++) begin
            drive(1'b0, 1'b0, '0, 1'b1);
            if (c >= 3) begin
                total++;
                if (bus_if.inst_valid !== 1'b1 || bus_if.inst_pc !== IMW'(c - 3)) begin
                    bad++;
                    $display("FAIL redir_pre_c%0d got=%b/%h want=1/%0d", c, bus_if.inst_valid, bus_if.inst_pc, c - 3);
                end
            end
        end
        total++; if ({bus_if.imem_en, bus_if.imem_addr} !== 5'h14) begin bad++; $display("FAIL redir_req4 got=%b/%h want=1/4", bus_if.imem_en, bus_if.imem_addr); end
        drive(1'b0, 1'b1, 4'd9, 1'b1);
        total++; if ({bus_if.inst_valid, bus_if.imem_en} !== 2'b00) begin bad++; $display("FAIL redir_cycle got=v%b/en%b want=v0/en0", bus_if.inst_valid, bus_if.imem_en); end
        drive(1'b0, 1'b0, '0, 1'b1);
        total++; if ({bus_if.imem_en, bus_if.imem_addr, bus_if.inst_valid} !== 6'b1_1001_0) begin bad++; $display("FAIL redir_r1 got=en%b/a%h/v%b want=en1/a9/v0", bus_if.imem_en, bus_if.imem_addr, bus_if.inst_valid); end
        drive(1'b0, 1'b0, '0, 1'b1);
        total++; if (bus_if.inst_valid !== 1'b0) begin bad++; $display("FAIL redir_r2_valid got=%b want=0", bus_if.inst_valid); end
        drive(1'b0, 1'b0, '0, 1'b1);
        total++; if ({bus_if.inst_valid, bus_if.inst_pc, bus_if.inst_data} !== 13'h1919) begin bad++; $display("FAIL redir_r3 got=%b/%h/%h want=1/9/19", bus_if.inst_valid, bus_if.inst_pc, bus_if.inst_data); end
    endtask

    task automatic test_start_branch();
        do_reset();
        drive(1'b1, 1'b0, '0, 1'b1);
        for (int c = 1; c < 5; c++) drive(1'b0, 1'b0, '0, 1'b1);
        drive(1'b1, 1'b1, 4'd7, 1'b1);
        total++; if ({bus_if.inst_valid, bus_if.imem_en} !== 2'b00) begin bad++; $display("FAIL sb_cycle got=v%b/en%b want=v0/en0", bus_if.inst_valid, bus_if.imem_en); end
        drive(1'b0, 1'b0, '0, 1'b1);
        total++; if ({bus_if.imem_en, bus_if.imem_addr} !== 5'h10) begin bad++; $display("FAIL sb_req got=%b/%h want=1/0", bus_if.imem_en, bus_if.imem_addr); end
        drive(1'b0, 1'b0, '0, 1'b1);
        drive(1'b0, 1'b0, '0, 1'b1);
        total++; if ({bus_if.inst_valid, bus_if.inst_pc, bus_if.inst_data} !== 13'h1010) begin bad++; $display("FAIL sb_first got=%b/%h/%h want=1/0/10", bus_if.inst_valid, bus_if.inst_pc, bus_if.inst_data); end
    endtask

    task automatic test_toggle();
        logic [IMW-1:0] exp_pc;
        logic           r;
        logic           br;
        int             post;
        exp_pc = '0;
        post   = 0;
        do_reset();
        drive(1'b1, 1'b0, '0, 1'b0);
        for (int cyc = 1; cyc <= 60; cyc++) begin
            r  = (cyc < 20 || cyc > 24) ? cyc[0] : 1'b0;
            br = (cyc == 24);
            drive(1'b0, br, 4'd12, r);
            if (cyc == 23) begin
                total++;
                if (bus_if.imem_en !== 1'b0 || bus_if.inst_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL tog_full got=en%b/v%b want=en0/v1", bus_if.imem_en, bus_if.inst_valid);
                end
            end
            if (br) begin
                total++;
                if (bus_if.inst_valid !== 1'b0) begin bad++; $display("FAIL tog_redir_valid got=%b want=0", bus_if.inst_valid); end
                exp_pc = 4'd12;
            end else if (bus_if.inst_valid === 1'b1 && r) begin
                total++;
                if (bus_if.inst_pc !== exp_pc || bus_if.inst_data !== (8'h10 + IW'(exp_pc))) begin
                    bad++;
                    $display("FAIL tog_accept_c%0d got=%h/%h want=%h/%h", cyc, bus_if.inst_pc, bus_if.inst_data, exp_pc, 8'h10 + IW'(exp_pc));
                end
                exp_pc = exp_pc + 4'd1;
                if (cyc > 24) post++;
            end
        end
        total++; if (post < 8) begin bad++; $display("FAIL tog_progress got=%0d want>=8", post); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        drive(1'b1, 1'b0, '0, 1'b0);
        for (int c = 1; c < 6; c++) drive(1'b0, 1'b0, '0, 1'b0);
        drive(1'b0, 1'b0, '0, 1'b1);
        total++; if ({bus_if.imem_en, bus_if.inst_valid} !== 2'b11) begin bad++; $display("FAIL mid_pre got=en%b/v%b want=en1/v1", bus_if.imem_en, bus_if.inst_valid); end
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus_if.imem_en, bus_if.imem_addr, bus_if.inst_valid, bus_if.inst_data, bus_if.inst_pc} !== 18'h0) begin
            bad++;
            $display("FAIL mid_reset_outs got=en%b/a%h/v%b/d%h/pc%h want=all0", bus_if.imem_en, bus_if.imem_addr, bus_if.inst_valid, bus_if.inst_data, bus_if.inst_pc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 1'b0, '0, 1'b1);
            total++;
            if ({bus_if.imem_en, bus_if.inst_valid} !== 2'b00) begin
                bad++;
                $display("FAIL mid_quiet_c%0d got=en%b/v%b want=en0/v0", c, bus_if.imem_en, bus_if.inst_valid);
            end
        end
        drive(1'b1, 1'b0, '0, 1'b1);
        drive(1'b0, 1'b0, '0, 1'b1);
        total++; if ({bus_if.imem_en, bus_if.imem_addr} !== 5'h10) begin bad++; $display("FAIL mid_restart_req got=%b/%h want=1/0", bus_if.imem_en, bus_if.imem_addr); end
        drive(1'b0, 1'b0, '0, 1'b1);
        drive(1'b0, 1'b0, '0, 1'b1);
        total++; if ({bus_if.inst_valid, bus_if.inst_pc, bus_if.inst_data} !== 13'h1010) begin bad++; $display("FAIL mid_restart_word got=%b/%h/%h want=1/0/10", bus_if.inst_valid, bus_if.inst_pc, bus_if.inst_data); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_start_branch();
        test_toggle();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
